// File: rtl/shift_issue_stage.sv
// ID/EX stage for the execute-stage shifter: decodes SLL/SRA/ROR, selects the
// forwarded rs operand, registers shifter inputs and counts issued shifts.
module shift_issue_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [15:0]       id_instr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic              exmem_wr_en,
  input  logic [3:0]        exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_wr_en,
  input  logic [3:0]        memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic              ex_valid,
  output logic              ex_is_shift,
  output logic [2:0]        ex_shift_op,
  output logic [3:0]        ex_shift_amt,
  output logic [DATA_W-1:0] ex_shift_in,
  output logic [3:0]        ex_rd,
  output logic              ex_wr_en,
  output logic [CNT_W-1:0]  shift_count
);

  localparam int unsigned REG_W = 4;
  localparam int unsigned OP_W  = 3;
  localparam int unsigned AMT_W = 4;
  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OPC_SLL = 4'h4;
  localparam logic [OPC_W-1:0] OPC_SRA = 4'h5;
  localparam logic [OPC_W-1:0] OPC_ROR = 4'h6;

  logic [OPC_W-1:0]  opcode_c;
  logic [REG_W-1:0]  rd_c;
  logic [REG_W-1:0]  rs_c;
  logic              is_shift_c;
  logic [OP_W-1:0]   op_c;
  logic [AMT_W-1:0]  amt_c;
  logic              wr_en_c;
  logic [DATA_W-1:0] fwd_c;
  logic [DATA_W-1:0] operand_c;
  logic              load_c;
  logic              bubble_c;

  assign opcode_c = id_instr[15:12];
  assign rd_c     = id_instr[11:8];
  assign rs_c     = id_instr[7:4];

  // Opcode decode; non-shift opcodes leave every shifter field at zero
  always_comb begin
    is_shift_c = 1'b0;
    op_c       = '0;
    amt_c      = '0;
    wr_en_c    = 1'b0;
    case (opcode_c)
      OPC_SLL: begin is_shift_c = 1'b1; op_c = 3'b000; end
      OPC_SRA: begin is_shift_c = 1'b1; op_c = 3'b001; end
      OPC_ROR: begin is_shift_c = 1'b1; op_c = 3'b010; end
      default: ;
    endcase
    if (is_shift_c) begin
      amt_c   = id_instr[3:0];
      wr_en_c = 1'b1;
    end
  end

  // Operand forwarding; R0 is hardwired to zero and never forwarded into
  always_comb begin
    fwd_c = id_rs_data;
    if (rs_c == '0)
      fwd_c = '0;
    else if (exmem_wr_en && (exmem_rd == rs_c))
      fwd_c = exmem_data;
    else if (memwb_wr_en && (memwb_rd == rs_c))
      fwd_c = memwb_data;
  end

  assign operand_c = is_shift_c ? fwd_c : '0;
  assign load_c    = !flush && !stall && id_valid;
  assign bubble_c  = flush || (!stall && !id_valid);

  // ID/EX register: flush beats stall, stall holds without re-sampling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_is_shift  <= 1'b0;
      ex_shift_op  <= '0;
      ex_shift_amt <= '0;
      ex_shift_in  <= '0;
      ex_rd        <= '0;
      ex_wr_en     <= 1'b0;
    end else if (bubble_c) begin
      ex_valid     <= 1'b0;
      ex_is_shift  <= 1'b0;
      ex_shift_op  <= '0;
      ex_shift_amt <= '0;
      ex_shift_in  <= '0;
      ex_rd        <= '0;
      ex_wr_en     <= 1'b0;
    end else if (load_c) begin
      ex_valid     <= 1'b1;
      ex_is_shift  <= is_shift_c;
      ex_shift_op  <= op_c;
      ex_shift_amt <= amt_c;
      ex_shift_in  <= operand_c;
      ex_rd        <= rd_c;
      ex_wr_en     <= wr_en_c;
    end
  end

  // Saturating issued-shift counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      shift_count <= '0;
    else if (load_c && is_shift_c && (shift_count != '1))
      shift_count <= shift_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_shift_issue_stage.sv
// Randomised and directed bench for shift_issue_stage against a field-level
// reference model; a second instance with a 4-bit counter covers saturation.
module tb_shift_issue_stage;

  localparam int unsigned DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall, flush, id_valid;
  logic [15:0]       id_instr;
  logic [DATA_W-1:0] id_rs_data, exmem_data, memwb_data;
  logic              exmem_wr_en, memwb_wr_en;
  logic [3:0]        exmem_rd, memwb_rd;

  logic              ex_valid, ex_is_shift, ex_wr_en;
  logic [2:0]        ex_shift_op;
  logic [3:0]        ex_shift_amt, ex_rd;
  logic [DATA_W-1:0] ex_shift_in;
  logic [15:0]       shift_count;

  logic              s_valid, s_is_shift, s_wr_en;
  logic [2:0]        s_shift_op;
  logic [3:0]        s_shift_amt, s_rd;
  logic [DATA_W-1:0] s_shift_in;
  logic [3:0]        s_count;

  int total = 0;
  int bad   = 0;

  // reference state
  logic              m_valid, m_is_shift, m_wr;
  logic [2:0]        m_op;
  logic [3:0]        m_amt, m_rd;
  logic [DATA_W-1:0] m_in;
  int                m_cnt, m_cnt4;

  always #5 clk = ~clk;

  shift_issue_stage #(.DATA_W(DATA_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_instr(id_instr), .id_rs_data(id_rs_data),
    .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .ex_valid(ex_valid), .ex_is_shift(ex_is_shift), .ex_shift_op(ex_shift_op),
    .ex_shift_amt(ex_shift_amt), .ex_shift_in(ex_shift_in), .ex_rd(ex_rd),
    .ex_wr_en(ex_wr_en), .shift_count(shift_count)
  );

  shift_issue_stage #(.DATA_W(DATA_W), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_instr(id_instr), .id_rs_data(id_rs_data),
    .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .ex_valid(s_valid), .ex_is_shift(s_is_shift), .ex_shift_op(s_shift_op),
    .ex_shift_amt(s_shift_amt), .ex_shift_in(s_shift_in), .ex_rd(s_rd),
    .ex_wr_en(s_wr_en), .shift_count(s_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},    32'(ex_valid),     32'(m_valid));
    chk({tag, ".is_shift"}, 32'(ex_is_shift),  32'(m_is_shift));
    chk({tag, ".op"},       32'(ex_shift_op),  32'(m_op));
    chk({tag, ".amt"},      32'(ex_shift_amt), 32'(m_amt));
    chk({tag, ".in"},       32'(ex_shift_in),  32'(m_in));
    chk({tag, ".rd"},       32'(ex_rd),        32'(m_rd));
    chk({tag, ".wr_en"},    32'(ex_wr_en),     32'(m_wr));
    chk({tag, ".count"},    32'(shift_count),  32'(m_cnt));
    chk({tag, ".count4"},   32'(s_count),      32'(m_cnt4));
  endtask

  task automatic model_clear(input logic clr_cnt);
    m_valid = 1'b0; m_is_shift = 1'b0; m_wr = 1'b0;
    m_op = '0; m_amt = '0; m_rd = '0; m_in = '0;
    if (clr_cnt) begin m_cnt = 0; m_cnt4 = 0; end
  endtask

  function automatic logic [DATA_W-1:0] pick_operand(input logic [3:0] rs);
    if (rs == 4'd0) return '0;
    if (exmem_wr_en && exmem_rd == rs) return exmem_data;
    if (memwb_wr_en && memwb_rd == rs) return memwb_data;
    return id_rs_data;
  endfunction

  // What the ID/EX register should hold after the coming edge
  task automatic model_edge();
    int opc;
    opc = int'(id_instr[15:12]);
    if (flush || (!stall && !id_valid)) begin
      model_clear(1'b0);
    end else if (!stall) begin
      m_valid = 1'b1;
      m_rd    = id_instr[11:8];
      if (opc >= 4 && opc <= 6) begin
        m_is_shift = 1'b1;
        m_op  = 3'(opc - 4);
        m_wr  = 1'b1;
        m_amt = id_instr[3:0];
        m_in  = pick_operand(id_instr[7:4]);
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end else begin
        m_is_shift = 1'b0; m_op = '0; m_wr = 1'b0; m_amt = '0; m_in = '0;
      end
    end
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_fwd(input logic ew, input logic [3:0] er, input logic [15:0] ed,
                         input logic mw, input logic [3:0] mr, input logic [15:0] md);
    exmem_wr_en = ew; exmem_rd = er; exmem_data = ed;
    memwb_wr_en = mw; memwb_rd = mr; memwb_data = md;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_instr = '0; id_rs_data = '0;
    set_fwd(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    model_clear(1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // plain decode, no hazard
    id_valid = 1'b1; id_instr = 16'h5312; id_rs_data = 16'h8001;
    cycle("decode_sra");

    // forwarding priority
    id_instr = 16'h6A4F; id_rs_data = 16'h1111;
    set_fwd(1'b1, 4'd4, 16'h2222, 1'b1, 4'd4, 16'h3333);
    cycle("fwd_exmem");
    exmem_wr_en = 1'b0;
    cycle("fwd_memwb");
    id_instr = 16'h6A0F;
    set_fwd(1'b1, 4'd0, 16'h2222, 1'b1, 4'd0, 16'h3333);
    cycle("fwd_r0");

    // stall holds, then flush wins over stall
    set_fwd(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    id_instr = 16'h4153; id_rs_data = 16'hBEEF;
    cycle("pre_stall");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_instr = 16'(5 + i) << 12 | 16'h0721; id_rs_data = 16'($urandom);
      cycle("stall");
    end
    flush = 1'b1;
    cycle("stall_flush");
    stall = 1'b0; flush = 1'b0;

    // non-shift opcode and idle bubble
    id_instr = 16'h0123; id_rs_data = 16'h7777;
    cycle("non_shift");
    id_valid = 1'b0;
    cycle("idle_bubble");

    // randomised traffic
    for (int i = 0; i < 300; i++) begin
      id_valid   = ($urandom_range(0, 9) != 0);
      stall      = ($urandom_range(0, 5) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      id_instr   = 16'($urandom);
      id_instr[7:4] = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 7) id_instr[15:12] = 4'($urandom_range(4, 6));
      id_rs_data = 16'($urandom);
      set_fwd(1'($urandom), 4'($urandom_range(0, 3)), 16'($urandom),
              1'($urandom), 4'($urandom_range(0, 3)), 16'($urandom));
      cycle("random");
    end

    // asynchronous reset mid-cycle with a valid instruction held
    stall = 1'b0; flush = 1'b0; id_valid = 1'b1;
    id_instr = 16'h4A35; id_rs_data = 16'h1234;
    set_fwd(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
    cycle("pre_reset");
    #3 rst = 1'b1;
    #1;
    model_clear(1'b1);
    check_all("async_reset");
    #1 rst = 1'b0;

    // back-to-back SLLs saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      id_instr = 16'h4000 | 16'(i & 15) | 16'h0110;
      id_rs_data = 16'($urandom);
      cycle("saturate");
    end
    chk("sat_final", 32'(s_count), 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
